pc_fetch_unit: RTL and testbench



---
 rtl/cpu_pkg.sv | 17 +
 rtl/pc_fetch_unit.sv | 114 +++++++++++
 tb/tb_pc_fetch_unit.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU types: address/word typedefs, fetch FSM states,
// and default fetch constants.
package cpu_pkg;

  typedef logic [31:0] addr_t;
  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } fetch_state_e;

  localparam addr_t RESET_PC_DEFAULT = 32'h0000_0000;
  localparam addr_t PC_STEP_DEFAULT  = 32'd4;

endpackage

// File: rtl/pc_fetch_unit.sv
// Fetch stage: holds the PC, issues one imem read at a time and
// presents {pc, pc+step, instr} to decode; accepts branch redirects.
// Ports: clk/rst (sync, active-high); imem_req/addr/rdata/rvalid;
// if_valid/if_pc/if_pc_next/if_instr with id_ready; br_taken/target.
module pc_fetch_unit
  import cpu_pkg::*;
#(
  parameter addr_t RESET_PC = RESET_PC_DEFAULT,
  parameter addr_t PC_STEP  = PC_STEP_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_rvalid,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_next,
  output logic [31:0] if_instr,
  input  logic        id_ready,
  input  logic        br_taken,
  input  logic [31:0] br_target
);

  fetch_state_e state_q, state_d;
  addr_t        pc_q, pc_d;
  logic         drop_q, drop_d;
  logic         valid_q, valid_d;
  addr_t        if_pc_q, if_pc_d;
  word_t        instr_q, instr_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_REQ;
      pc_q    <= RESET_PC;
      drop_q  <= 1'b0;
      valid_q <= 1'b0;
      if_pc_q <= RESET_PC;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      drop_q  <= drop_d;
      valid_q <= valid_d;
      if_pc_q <= if_pc_d;
      instr_q <= instr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    drop_d  = drop_q;
    valid_d = valid_q;
    if_pc_d = if_pc_q;
    instr_d = instr_q;
    if (br_taken) begin
      pc_d    = br_target;
      valid_d = 1'b0;
      unique case (state_q)
        // The request still goes out; its response must be dropped.
        S_REQ: begin
          drop_d  = 1'b1;
          state_d = S_WAIT;
        end
        // Data arriving with the redirect is stale: drop it inline.
        S_WAIT: begin
          if (imem_rvalid) begin
            drop_d  = 1'b0;
            state_d = S_REQ;
          end else begin
            drop_d  = 1'b1;
          end
        end
        S_HOLD:  state_d = S_REQ;
        default: state_d = S_REQ;
      endcase
    end else begin
      unique case (state_q)
        S_REQ: state_d = S_WAIT;
        S_WAIT: begin
          if (imem_rvalid) begin
            if (drop_q) begin
              drop_d  = 1'b0;
              state_d = S_REQ;
            end else begin
              instr_d = imem_rdata;
              if_pc_d = pc_q;
              valid_d = 1'b1;
              state_d = S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (id_ready) begin
            pc_d    = pc_q + PC_STEP;
            valid_d = 1'b0;
            state_d = S_REQ;
          end
        end
        default: state_d = S_REQ;
      endcase
    end
  end

  assign imem_req   = (state_q == S_REQ) && !rst;
  assign imem_addr  = pc_q;
  assign if_valid   = valid_q;
  assign if_pc      = if_pc_q;
  assign if_pc_next = if_pc_q + PC_STEP;
  assign if_instr   = instr_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed self-checking bench for pc_fetch_unit.
// Inputs change 1ns after each rising edge; outputs checked there.
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_rvalid;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_pc_next;
  logic [31:0] if_instr;
  logic        id_ready;
  logic        br_taken;
  logic [31:0] br_target;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pc_fetch_unit dut (
    .clk        (clk),
    .rst        (rst),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .imem_rvalid(imem_rvalid),
    .if_valid   (if_valid),
    .if_pc      (if_pc),
    .if_pc_next (if_pc_next),
    .if_instr   (if_instr),
    .id_ready   (id_ready),
    .br_taken   (br_taken),
    .br_target  (br_target)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic v,
                         input logic [31:0] pc,
                         input logic [31:0] ins);
    chk({tag, ".valid"}, {31'd0, if_valid}, {31'd0, v});
    chk({tag, ".pc"}, if_pc, pc);
    chk({tag, ".instr"}, if_instr, ins);
  endtask

  task automatic chk_req(input string tag, input logic r,
                         input logic [31:0] a);
    chk({tag, ".req"}, {31'd0, imem_req}, {31'd0, r});
    if (r) chk({tag, ".addr"}, imem_addr, a);
  endtask

  initial begin
    rst = 1'b1;
    imem_rdata = '0;
    imem_rvalid = 1'b0;
    id_ready = 1'b0;
    br_taken = 1'b0;
    br_target = '0;
    step();
    step();
    chk_out("rst", 1'b0, 32'h0, 32'h0);
    chk_req("rst", 1'b0, 32'h0);

    // First fetch, zero-wait memory
    rst = 1'b0;
    #1;
    chk_req("f0", 1'b1, 32'h0);
    step();
    chk_req("f0w", 1'b0, 32'h0);
    imem_rvalid = 1'b1;
    imem_rdata = 32'hAAAA0001;
    step();
    imem_rvalid = 1'b0;
    chk_out("f0h", 1'b1, 32'h0, 32'hAAAA0001);
    chk("f0h.next", if_pc_next, 32'h4);

    // Decode stall for 5 cycles
    for (int i = 0; i < 5; i++) begin
      step();
      chk_out("stall", 1'b1, 32'h0, 32'hAAAA0001);
      chk_req("stall", 1'b0, 32'h0);
    end
    id_ready = 1'b1;
    step();
    id_ready = 1'b0;
    chk_req("f1", 1'b1, 32'h4);
    chk("f1.valid", {31'd0, if_valid}, 32'd0);

    // Serve pc=4 and accept it
    step();
    imem_rvalid = 1'b1;
    imem_rdata = 32'h22220004;
    step();
    imem_rvalid = 1'b0;
    chk_out("f1h", 1'b1, 32'h4, 32'h22220004);
    id_ready = 1'b1;
    step();
    id_ready = 1'b0;

    // Redirect in S_REQ at pc=8
    chk_req("f2", 1'b1, 32'h8);
    br_taken = 1'b1;
    br_target = 32'h0000_0200;
    step();
    br_taken = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata = 32'hBAD00008;
    step();
    imem_rvalid = 1'b0;
    chk("rq.valid", {31'd0, if_valid}, 32'd0);
    chk_req("rq", 1'b1, 32'h200);
    step();
    imem_rvalid = 1'b1;
    imem_rdata = 32'h33330200;
    step();
    imem_rvalid = 1'b0;
    chk_out("rqh", 1'b1, 32'h200, 32'h33330200);
    chk("rqh.next", if_pc_next, 32'h204);
    id_ready = 1'b1;
    step();
    id_ready = 1'b0;
    chk_req("f3", 1'b1, 32'h204);

    // Redirect in S_WAIT, then stale data arrives
    step();
    br_taken = 1'b1;
    br_target = 32'h0000_0100;
    step();
    br_taken = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata = 32'hDEAD0000;
    chk("rw.valid", {31'd0, if_valid}, 32'd0);
    step();
    imem_rvalid = 1'b0;
    chk("rw2.valid", {31'd0, if_valid}, 32'd0);
    chk_req("rw", 1'b1, 32'h100);

    // Serve 0x100, then redirect from S_HOLD (id_ready ignored)
    step();
    imem_rvalid = 1'b1;
    imem_rdata = 32'h44440100;
    step();
    imem_rvalid = 1'b0;
    chk_out("rwh", 1'b1, 32'h100, 32'h44440100);
    br_taken = 1'b1;
    br_target = 32'hFFFF_FFFC;
    id_ready = 1'b1;
    step();
    br_taken = 1'b0;
    id_ready = 1'b0;
    chk("rh.valid", {31'd0, if_valid}, 32'd0);
    chk_req("rh", 1'b1, 32'hFFFF_FFFC);

    // Wrap-around of pc+step
    step();
    imem_rvalid = 1'b1;
    imem_rdata = 32'h5555FFFC;
    step();
    imem_rvalid = 1'b0;
    chk_out("wrap", 1'b1, 32'hFFFF_FFFC, 32'h5555FFFC);
    chk("wrap.next", if_pc_next, 32'h0);
    id_ready = 1'b1;
    step();
    id_ready = 1'b0;
    chk_req("wrapn", 1'b1, 32'h0);

    // Reset while a response is pending
    step();
    rst = 1'b1;
    step();
    chk_out("mrst", 1'b0, 32'h0, 32'h0);
    chk_req("mrst", 1'b0, 32'h0);
    rst = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata = 32'h66660000;
    #1;
    chk_req("late", 1'b1, 32'h0);
    step();
    imem_rvalid = 1'b0;
    chk_out("late", 1'b0, 32'h0, 32'h0);
    chk_req("latew", 1'b0, 32'h0);
    imem_rvalid = 1'b1;
    imem_rdata = 32'h77770000;
    step();
    imem_rvalid = 1'b0;
    chk_out("rstf", 1'b1, 32'h0, 32'h77770000);
    chk("rstf.next", if_pc_next, 32'h4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
